sipo_deframer: RTL and testbench
================================

# sipo_deframer

Serial-to-parallel receive stage that sits directly downstream of the team's parallel-in serial-out shift register. It samples an MSB-first bit stream under a per-bit strobe, frames WIDTH bits after a start pulse, and presents each completed word through a valid/ready output handshake with a one-word holding register. Words that complete while the holding register is still occupied are dropped. An optional sticky overrun flag reports those drops.

## Interface
- WIDTH, 8, word size in bits; legal range WIDTH >= 2.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- serial_in  input  1  serial data bit, MSB first.
- shift_en  input  1  bit strobe; serial_in is valid in this cycle.
- start  input  1  frame sync pulse; begins a new frame.
- data_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  completed word; reset value 0.
- data_valid  output  1  data_out holds an unconsumed word; reset value 0.
- busy  output  1  frame in progress (state SHIFT); reset value 0.
- overrun_clr  input  1  clears the overrun flag; present only with SIPO_OVERRUN_EN.
- overrun  output  1  sticky dropped-word flag; reset value 0; present only with SIPO_OVERRUN_EN.

## Operation
- **State machine.** The block has two states, IDLE and SHIFT, and resets to IDLE.
- **Leaving IDLE.** start=1 moves the block to SHIFT and clears the bit counter and shift register. The start cycle never samples serial_in. shift_en in IDLE is ignored.
- **Sampling in SHIFT.** Each cycle with shift_en=1 and start=0 does two things:
  - shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
  - bit counter +1. The counter is $clog2(WIDTH) bits wide.
- **Frame completion.** The sample taken when counter == WIDTH-1 completes the frame. The word is {shift_reg[WIDTH-2:0], serial_in}. The state returns to IDLE and the counter returns to 0. A new start is required before the next frame.
- **start in SHIFT.** start=1 aborts the partial frame and discards its bits. The counter clears and the state stays SHIFT. start has priority over shift_en in the same cycle.
- **Holding register and handshake.** A completed word is written to data_out and sets data_valid when either condition holds:
  - data_valid=0, or
  - data_valid=1 and data_ready=1 in the same cycle. In this case the old word is consumed, the new word replaces it and data_valid stays 1.
- **Consume only.** data_valid=1 with data_ready=1 and no completion that cycle clears data_valid. data_out retains its last value.
- **Drop.** A completion while data_valid=1 and data_ready=0 drops the new word. data_out and data_valid are unchanged.
- **data_out stability.** data_out changes only on a load.
- **busy.** busy = (state == SHIFT).
- **Reset.** rst at any time, including mid-frame or with data_valid high, returns the block to IDLE. It clears the counter, shift_reg, data_out, data_valid and overrun.

## Timing
- **Latency.** data_valid rises on the clock edge that samples the final bit. It is visible in the cycle after the last shift_en cycle.
- **Minimum frame.** 1 start cycle + WIDTH strobe cycles. Strobes may have gaps of any length.
- **Handshake.** A transfer occurs on any edge with data_valid=1 and data_ready=1. data_ready may be held high permanently. There is no combinational path from data_ready to data_valid.
- **Registered outputs.** All outputs come straight from flip-flops. There are no combinational paths from inputs to outputs.

## Configuration
- **Macro SIPO_OVERRUN_EN.**
  - **Defined:** the overrun_clr input and overrun output exist. A drop sets overrun=1 on that edge, and it stays set. overrun_clr=1 clears it. A drop in the same cycle as overrun_clr leaves overrun=1 (set wins).
  - **Undefined:** both ports are absent. Drops are silent. All other behaviour is identical.

## Test plan
- **Reset values.** Assert rst mid-simulation with random inputs -> data_out=0, data_valid=0, busy=0, overrun=0 immediately (asynchronous).
- **Single frame.** WIDTH=8: start, then 8 strobes of 1,0,1,0,0,1,0,1 -> data_out=8'hA5 and data_valid=1 in the cycle after the 8th strobe, busy=0 in that cycle. With data_ready=1 one cycle later -> data_valid=0.
- **Drop with backpressure.** Hold data_ready=0, then receive 8'h3C followed by 8'hC3 -> data_out stays 8'h3C and data_valid stays 1. With the macro, overrun=1 after the second frame, and overrun_clr for one cycle -> overrun=0.
- **Simultaneous consume and complete.** data_valid=1 with 8'h11, and data_ready=1 on the edge that completes 8'h22 -> data_out=8'h22, data_valid stays 1, overrun stays 0.
- **Abort.** start, 5 strobes of 1, start again, then 8 strobes of 0 -> exactly one word, 8'h00. No word is produced for the aborted frame. start and shift_en in the same cycle do not sample.
- **Mid-frame reset.** Reset after 4 strobes, release, start, 8 strobes of 1 -> a single word 8'hFF.

Source files
------------

// File: rtl/sipo_deframer_if.sv
// Handshake/bus bundle for sipo_deframer. The overrun_clr/overrun pair exists only when
// SIPO_OVERRUN_EN is defined.
interface sipo_deframer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             serial_in;
    logic             shift_en;
    logic             start;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
`ifdef SIPO_OVERRUN_EN
    logic             overrun_clr;
    logic             overrun;
`endif

    // master: the deframer itself; slave: the stream source and word consumer.
    modport master (
        input  serial_in,
        input  shift_en,
        input  start,
        input  data_ready,
`ifdef SIPO_OVERRUN_EN
        input  overrun_clr,
        output overrun,
`endif
        output data_out,
        output data_valid,
        output busy
    );

    modport slave (
        output serial_in,
        output shift_en,
        output start,
        output data_ready,
`ifdef SIPO_OVERRUN_EN
        output overrun_clr,
        input  overrun,
`endif
        input  data_out,
        input  data_valid,
        input  busy
    );
endinterface

// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with a one-word valid/ready holding register.
// Optional sticky overrun flag is enabled by defining SIPO_OVERRUN_EN.
module sipo_deframer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    sipo_deframer_if.master    bus
);
    localparam int unsigned    CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
    localparam logic [0:0]     ST_IDLE  = 1'b0;
    localparam logic [0:0]     ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    // Only WIDTH-1 bits are kept; the final bit goes straight into the word.
    logic [WIDTH-2:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_sample;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_word;

    assign w_sample = (r_state == ST_SHIFT) && bus.shift_en && !bus.start;
    assign w_last   = w_sample && (r_cnt == LAST);
    assign w_word   = {r_shift, bus.serial_in};
    assign w_load   = w_last && (!r_valid || bus.data_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (bus.start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_sample) begin
            r_cnt   <= r_cnt + CW'(1);
            r_shift <= w_word[WIDTH-2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
        end else if (r_valid && bus.data_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SIPO_OVERRUN_EN
    logic w_drop;
    logic r_overrun;

    assign w_drop = w_last && r_valid && !bus.data_ready;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign bus.overrun = r_overrun;
`endif

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_state;
endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: a frame-level reference model checked every cycle
// plus directed vectors with literal expectations. Build with SIPO_OVERRUN_EN to cover overrun.
module tb_sipo_deframer;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sipo_deframer_if #(.WIDTH(WIDTH)) u_if ();

    sipo_deframer #(.WIDTH(WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is "active" after start; bits accumulate arithmetically.
    bit m_active;
    int m_nbits;
    int m_acc;
    bit m_valid;
    int m_data;
    bit m_ovr;
    bit m_clr;

    wire m_sample = m_active && u_if.shift_en && !u_if.start;
    wire m_done   = m_sample && (m_nbits == WIDTH - 1);
    wire [31:0] m_word = 32'(m_acc * 2 + int'(u_if.serial_in));

`ifdef SIPO_OVERRUN_EN
    assign m_clr = u_if.overrun_clr;
`else
    assign m_clr = 1'b0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_nbits  <= 0;
            m_acc    <= 0;
            m_valid  <= 1'b0;
            m_data   <= 0;
            m_ovr    <= 1'b0;
        end else begin
            if (u_if.start) begin
                m_active <= 1'b1;
                m_nbits  <= 0;
                m_acc    <= 0;
            end else if (m_done) begin
                m_active <= 1'b0;
                m_nbits  <= 0;
                m_acc    <= 0;
            end else if (m_sample) begin
                m_nbits  <= m_nbits + 1;
                m_acc    <= int'(m_word);
            end
            if (m_done && (!m_valid || u_if.data_ready)) begin
                m_valid <= 1'b1;
                m_data  <= int'(m_word);
            end else if (m_valid && u_if.data_ready) begin
                m_valid <= 1'b0;
            end
            if (m_done && m_valid && !u_if.data_ready) m_ovr <= 1'b1;
            else if (m_clr)                            m_ovr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model data_valid", int'(u_if.data_valid), int'(m_valid));
            check("model data_out", int'(u_if.data_out), m_data);
            check("model busy", int'(u_if.busy), int'(m_active));
`ifdef SIPO_OVERRUN_EN
            check("model overrun", int'(u_if.overrun), int'(m_ovr));
`endif
        end
    end

    // Log of words actually transferred to the consumer.
    int got_q[$];
    always @(posedge clk) begin
        if (!rst && u_if.data_valid && u_if.data_ready) got_q.push_back(int'(u_if.data_out));
    end

    task automatic cyc(input bit st, input bit en, input bit b);
        u_if.start     = st;
        u_if.shift_en  = en;
        u_if.serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " data_out"}, int'(u_if.data_out), 0);
        check({tag, " data_valid"}, int'(u_if.data_valid), 0);
        check({tag, " busy"}, int'(u_if.busy), 0);
`ifdef SIPO_OVERRUN_EN
        check({tag, " overrun"}, int'(u_if.overrun), 0);
`endif
    endtask

    task automatic set_ovr_clr(input bit v);
`ifdef SIPO_OVERRUN_EN
        u_if.overrun_clr = v;
`else
        if (v) begin end
`endif
    endtask

    task automatic check_ovr(input string name, input int exp);
`ifdef SIPO_OVERRUN_EN
        check(name, int'(u_if.overrun), exp);
`else
        if (exp < 0) $display("%s", name);
`endif
    endtask

    initial begin
        u_if.start = 1'b0; u_if.shift_en = 1'b0; u_if.serial_in = 1'b0; u_if.data_ready = 1'b0;
        set_ovr_clr(1'b0);
        @(posedge clk); #1;
        check_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame A5; shift_en in IDLE is ignored.
        cyc(1'b0, 1'b1, 1'b1);
        check("idle busy", int'(u_if.busy), 0);
        send_frame(8'hA5);
        check("a5 data_out", int'(u_if.data_out), 'hA5);
        check("a5 data_valid", int'(u_if.data_valid), 1);
        check("a5 busy", int'(u_if.busy), 0);
        u_if.data_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("a5 consumed valid", int'(u_if.data_valid), 0);
        check("a5 retained data_out", int'(u_if.data_out), 'hA5);
        u_if.data_ready = 1'b0;

        // Backpressure drop.
        send_frame(8'h3C);
        send_frame(8'hC3);
        check("drop data_out", int'(u_if.data_out), 'h3C);
        check("drop data_valid", int'(u_if.data_valid), 1);
        check_ovr("drop overrun set", 1);
        set_ovr_clr(1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        set_ovr_clr(1'b0);
        check_ovr("overrun cleared", 0);
        u_if.data_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        u_if.data_ready = 1'b0;
        check("drain valid", int'(u_if.data_valid), 0);

        // Consume 11 on the same edge that completes 22.
        send_frame(8'h11);
        check("hold 11", int'(u_if.data_out), 'h11);
        begin
            logic [WIDTH-1:0] w22;
            w22 = 8'h22;
            cyc(1'b1, 1'b0, 1'b0);
            for (int i = WIDTH - 1; i >= 1; i--) cyc(1'b0, 1'b1, w22[i]);
            u_if.data_ready = 1'b1;
            cyc(1'b0, 1'b1, w22[0]);
        end
        check("simul data_out", int'(u_if.data_out), 'h22);
        check("simul data_valid", int'(u_if.data_valid), 1);
        check_ovr("simul overrun", 0);
        cyc(1'b0, 1'b0, 1'b0);
        check("simul drained", int'(u_if.data_valid), 0);

        // Abort: start+shift_en in the same cycle must not sample.
        got_q.delete();
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("abort busy", int'(u_if.busy), 1);
        for (int i = 0; i < WIDTH; i++) cyc(1'b0, 1'b1, 1'b0);
        check("abort completes on 8th", int'(u_if.busy), 0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("abort word count", got_q.size(), 1);
        if (got_q.size() > 0) check("abort word", got_q[0], 'h00);
        u_if.data_ready = 1'b0;

        // Mid-frame reset with a word pending and random inputs.
        send_frame(8'h5A);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        check("pre-reset busy", int'(u_if.busy), 1);
        u_if.start      = 1'($urandom);
        u_if.shift_en   = 1'($urandom);
        u_if.serial_in  = 1'($urandom);
        u_if.data_ready = 1'($urandom);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async rst");
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.shift_en = 1'b0; u_if.serial_in = 1'b0; u_if.data_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        send_frame(8'hFF);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("post-reset word count", got_q.size(), 1);
        if (got_q.size() > 0) check("post-reset word", got_q[0], 'hFF);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
